lc3_pipe_ctrl: RTL and testbench

Pipeline controller for the LC3 core. It drives the stage enables for updatePC, fetch, decode, execute and writeback, and sequences the data-memory state machine for loads and stores. It also resolves control hazards for BR and JMP, and raises ALU forwarding selects toward the execute stage. It consumes the execute stage's registered outputs (IR_Exec, NZP) together with the decode-stage IR, the instruction-memory word and the writeback PSR.

---
 rtl/lc3_ctrl_pkg.sv | 35 +++
 rtl/lc3_mem_fsm.sv | 61 ++++++
 rtl/lc3_pipe_ctrl.sv | 123 ++++++++++++
 tb/tb_lc3_pipe_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/lc3_ctrl_pkg.sv
// Shared opcode constants, memory-state encoding and opcode classifiers
// for the LC3 pipeline controller.
package lc3_ctrl_pkg;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;

  typedef enum logic [1:0] {
    MS_READ     = 2'b00,
    MS_WRITE    = 2'b01,
    MS_INDIRECT = 2'b10,
    MS_IDLE     = 2'b11
  } mem_state_t;

  function automatic logic is_mem_op(input logic [3:0] opcode);
    case (opcode)
      OP_LD, OP_LDR, OP_LDI, OP_ST, OP_STR, OP_STI: return 1'b1;
      default:                                      return 1'b0;
    endcase
  endfunction

  function automatic logic is_alu_op(input logic [3:0] opcode);
    return (opcode == OP_ADD) || (opcode == OP_AND) || (opcode == OP_NOT);
  endfunction

endpackage

// File: rtl/lc3_mem_fsm.sv
// Data-memory sequencer: one access cycle for direct loads/stores, an extra
// INDIRECT pointer-fetch cycle in front for LDI/STI.
module lc3_mem_fsm
  import lc3_ctrl_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] opcode,
  output mem_state_t mem_state,
  output logic       stall,
  output logic       wb_en
);

  // Remembers whether the pending indirect access ends in a write or a read.
  logic ind_store;

  // NOTE: every register here is assigned with <= so all state updates on the
  // same edge see the pre-edge values; blocking writes would create ordering bugs.
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_state <= MS_IDLE;
      stall     <= 1'b0;
      wb_en     <= 1'b0;
      ind_store <= 1'b0;
    end else begin
      case (mem_state)
        MS_IDLE: begin
          if (start && is_mem_op(opcode)) begin
            stall     <= 1'b1;
            ind_store <= (opcode == OP_STI);
            case (opcode)
              OP_LD, OP_LDR: begin
                mem_state <= MS_READ;
                wb_en     <= 1'b1;
              end
              OP_ST, OP_STR: begin
                mem_state <= MS_WRITE;
                wb_en     <= 1'b0;
              end
              default: begin
                mem_state <= MS_INDIRECT;
                wb_en     <= 1'b0;
              end
            endcase
          end
        end
        MS_INDIRECT: begin
          mem_state <= ind_store ? MS_WRITE : MS_READ;
          wb_en     <= !ind_store;
        end
        default: begin
          mem_state <= MS_IDLE;
          stall     <= 1'b0;
          wb_en     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/lc3_pipe_ctrl.sv
// LC3 pipeline controller: stage-enable shift chain, BR/JMP bubble counter,
// memory-stall sequencing and ALU forwarding selects.
module lc3_pipe_ctrl
  import lc3_ctrl_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] IMem_dout,
  input  logic [15:0] IR,
  input  logic [15:0] IR_Exec,
  input  logic [2:0]  NZP,
  input  logic [2:0]  psr,
  output logic        enable_updatePC,
  output logic        enable_fetch,
  output logic        enable_decode,
  output logic        enable_execute,
  output logic        enable_writeback,
  output logic        br_taken,
  output logic [1:0]  mem_state,
  output logic        bypass_alu_1,
  output logic        bypass_alu_2
);

  logic [3:0] op_d;
  logic [3:0] op_e;
  logic [2:0] dr_e;
  assign op_d = IR[15:12];
  assign op_e = IR_Exec[15:12];
  assign dr_e = IR_Exec[11:9];

  // The instruction-memory word and execute-out codes are not needed to
  // sequence the pipeline; branch resolution uses the writeback PSR.
  logic unused_inputs;
  assign unused_inputs = ^{IMem_dout, NZP, IR[4:3], IR_Exec[8:0]};

  mem_state_t ms;
  logic       stall;
  logic       mem_wb_en;
  logic       mem_start;
  logic       hold;

  logic       pc_q, fetch_q, dec_q, exe_q, wb_q;
  logic [1:0] br_cnt;
  logic       br_is_jmp;
  logic       br_detect;
  logic       br_cond;

  lc3_mem_fsm u_mem_fsm (
    .clock     (clock),
    .reset     (reset),
    .start     (mem_start),
    .opcode    (op_e),
    .mem_state (ms),
    .stall     (stall),
    .wb_en     (mem_wb_en)
  );

  // The chain registers keep their pre-stall values; the stall only masks them.
  assign enable_updatePC  = pc_q    & ~stall;
  assign enable_fetch     = fetch_q & ~stall;
  assign enable_decode    = dec_q   & ~stall;
  assign enable_execute   = exe_q   & ~stall;
  assign enable_writeback = stall ? mem_wb_en : wb_q;
  assign mem_state        = ms;

  assign mem_start = enable_execute && is_mem_op(op_e);
  assign hold      = stall || mem_start;
  assign br_detect = enable_decode && (op_d == OP_BR || op_d == OP_JMP) && (br_cnt == 2'd0);
  assign br_cond   = br_is_jmp || (|(dr_e & psr));

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q      <= 1'b0;
      fetch_q   <= 1'b0;
      dec_q     <= 1'b0;
      exe_q     <= 1'b0;
      wb_q      <= 1'b0;
      br_cnt    <= 2'd0;
      br_is_jmp <= 1'b0;
      br_taken  <= 1'b0;
    end else if (!hold) begin
      exe_q    <= dec_q;
      wb_q     <= exe_q;
      br_taken <= 1'b0;
      if (br_detect) begin
        pc_q      <= 1'b0;
        fetch_q   <= 1'b0;
        dec_q     <= 1'b0;
        br_cnt    <= 2'd2;
        br_is_jmp <= (op_d == OP_JMP);
      end else if (br_cnt == 2'd2) begin
        pc_q    <= 1'b0;
        fetch_q <= 1'b0;
        dec_q   <= 1'b0;
        br_cnt  <= 2'd1;
      end else if (br_cnt == 2'd1) begin
        // The branch sits in execute-out now, so its nzp field is visible.
        pc_q     <= 1'b1;
        fetch_q  <= 1'b1;
        dec_q    <= fetch_q;
        br_cnt   <= 2'd0;
        br_taken <= br_cond;
      end else begin
        pc_q    <= 1'b1;
        fetch_q <= 1'b1;
        dec_q   <= fetch_q;
      end
    end else begin
      br_taken <= 1'b0;
    end
  end

  logic alu_in_exe;
  assign alu_in_exe = enable_execute && is_alu_op(op_e);

  assign bypass_alu_1 = alu_in_exe && (IR[8:6] == dr_e) &&
                        (is_alu_op(op_d) || op_d == OP_LDR || op_d == OP_STR || op_d == OP_JMP);

  assign bypass_alu_2 = alu_in_exe &&
                        ((((op_d == OP_ADD) || (op_d == OP_AND)) && !IR[5] && (IR[2:0] == dr_e)) ||
                         (((op_d == OP_ST) || (op_d == OP_STR) || (op_d == OP_STI)) && (IR[11:9] == dr_e)));

endmodule

// File: tb/tb_lc3_pipe_ctrl.sv
// Directed bench for lc3_pipe_ctrl: fill, memory stalls, branches, forwarding, reset.
module tb_lc3_pipe_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] IMem_dout, IR, IR_Exec;
  logic [2:0]  NZP, psr;
  logic        enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback;
  logic        br_taken, bypass_alu_1, bypass_alu_2;
  logic [1:0]  mem_state;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [15:0] NOP_AND = 16'h5020;

  lc3_pipe_ctrl dut (
    .clock            (clock),
    .reset            (reset),
    .IMem_dout        (IMem_dout),
    .IR               (IR),
    .IR_Exec          (IR_Exec),
    .NZP              (NZP),
    .psr              (psr),
    .enable_updatePC  (enable_updatePC),
    .enable_fetch     (enable_fetch),
    .enable_decode    (enable_decode),
    .enable_execute   (enable_execute),
    .enable_writeback (enable_writeback),
    .br_taken         (br_taken),
    .mem_state        (mem_state),
    .bypass_alu_1     (bypass_alu_1),
    .bypass_alu_2     (bypass_alu_2)
  );

  always #5 clock = ~clock;

  logic [4:0] en_vec;
  assign en_vec = {enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback};

  task automatic test_reset();
    logic [4:0] fill [4] = '{5'b11000, 5'b11100, 5'b11110, 5'b11111};
    reset = 1'b1;
    repeat (3) @(negedge clock);
    n_checks++;
    if (en_vec !== 5'b00000) begin n_fail++; $display("FAIL reset enables: got %b expected 00000", en_vec); end
    n_checks++;
    if (mem_state !== 2'b11) begin n_fail++; $display("FAIL reset mem_state: got %b expected 11", mem_state); end
    n_checks++;
    if ({br_taken, bypass_alu_1, bypass_alu_2} !== 3'b000)
      begin n_fail++; $display("FAIL reset br/bypass: got %b expected 000", {br_taken, bypass_alu_1, bypass_alu_2}); end
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      n_checks++;
      if (en_vec !== fill[k]) begin n_fail++; $display("FAIL fill +%0d enables: got %b expected %b", k + 1, en_vec, fill[k]); end
      n_checks++;
      if (mem_state !== 2'b11) begin n_fail++; $display("FAIL fill +%0d mem_state: got %b expected 11", k + 1, mem_state); end
    end
  endtask

  // ms/ev pack the expected mem_state / enable vector per cycle, cycle 0 in the LSBs.
  task automatic test_mem_op(input logic [15:0] instr, input int cycles,
                             input logic [5:0] ms, input logic [14:0] ev, input string name);
    IR_Exec = instr;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clock);
      if (k == 0) IR_Exec = NOP_AND;
      n_checks++;
      if (mem_state !== ms[k*2 +: 2])
        begin n_fail++; $display("FAIL %s mem_state +%0d: got %b expected %b", name, k + 1, mem_state, ms[k*2 +: 2]); end
      n_checks++;
      if (en_vec !== ev[k*5 +: 5])
        begin n_fail++; $display("FAIL %s enables +%0d: got %b expected %b", name, k + 1, en_vec, ev[k*5 +: 5]); end
    end
  endtask

  task automatic test_back_to_back();
    IR_Exec = 16'h2000;  // LD R0
    @(negedge clock);
    IR_Exec = 16'h3000;  // ST R0 waiting behind the load
    n_checks++;
    if (mem_state !== 2'b00) begin n_fail++; $display("FAIL b2b first READ: got %b expected 00", mem_state); end
    @(negedge clock);
    n_checks++;
    if (mem_state !== 2'b11 || en_vec !== 5'b11111)
      begin n_fail++; $display("FAIL b2b gap: got ms=%b en=%b expected ms=11 en=11111", mem_state, en_vec); end
    @(negedge clock);
    IR_Exec = NOP_AND;
    n_checks++;
    if (mem_state !== 2'b01 || en_vec !== 5'b00000)
      begin n_fail++; $display("FAIL b2b second WRITE: got ms=%b en=%b expected ms=01 en=00000", mem_state, en_vec); end
    @(negedge clock);
    n_checks++;
    if (mem_state !== 2'b11 || en_vec !== 5'b11111)
      begin n_fail++; $display("FAIL b2b recover: got ms=%b en=%b expected ms=11 en=11111", mem_state, en_vec); end
  endtask

  task automatic test_branch(input logic [15:0] instr, input logic [2:0] p,
                             input logic exp_taken, input string name);
    logic [4:0] exp_vec [4] = '{5'b00011, 5'b00001, 5'b11000, 5'b11100};
    logic       exp_br;
    IR = instr;
    IR_Exec = instr;
    psr = p;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      if (k == 0) IR = NOP_AND;
      exp_br = (k == 2) ? exp_taken : 1'b0;
      n_checks++;
      if (en_vec !== exp_vec[k])
        begin n_fail++; $display("FAIL %s enables t+%0d: got %b expected %b", name, k + 1, en_vec, exp_vec[k]); end
      n_checks++;
      if (br_taken !== exp_br)
        begin n_fail++; $display("FAIL %s br_taken t+%0d: got %b expected %b", name, k + 1, br_taken, exp_br); end
    end
    repeat (2) @(negedge clock);
    n_checks++;
    if (en_vec !== 5'b11111) begin n_fail++; $display("FAIL %s refill: got %b expected 11111", name, en_vec); end
    IR_Exec = NOP_AND;
    psr = 3'b000;
  endtask

  task automatic test_forwarding();
    IR_Exec = 16'h1261;  // ADD R1,R1,#1
    IR = 16'h1441;       // ADD R2,R1,R1
    #1;
    n_checks++;
    if ({bypass_alu_1, bypass_alu_2} !== 2'b11)
      begin n_fail++; $display("FAIL fwd add-reg: got %b expected 11", {bypass_alu_1, bypass_alu_2}); end
    IR = 16'h1461;       // ADD R2,R1,#1
    #1;
    n_checks++;
    if ({bypass_alu_1, bypass_alu_2} !== 2'b10)
      begin n_fail++; $display("FAIL fwd add-imm: got %b expected 10", {bypass_alu_1, bypass_alu_2}); end
    IR = 16'h3200;       // ST R1
    #1;
    n_checks++;
    if ({bypass_alu_1, bypass_alu_2} !== 2'b01)
      begin n_fail++; $display("FAIL fwd store: got %b expected 01", {bypass_alu_1, bypass_alu_2}); end
    IR_Exec = 16'hE261;  // LEA R1 is not an ALU producer
    IR = 16'h1441;
    #1;
    n_checks++;
    if ({bypass_alu_1, bypass_alu_2} !== 2'b00)
      begin n_fail++; $display("FAIL fwd non-alu: got %b expected 00", {bypass_alu_1, bypass_alu_2}); end
    IR = NOP_AND;
    IR_Exec = NOP_AND;
  endtask

  task automatic test_reset_mid_ldi();
    IR_Exec = 16'hA005;
    @(negedge clock);
    IR_Exec = NOP_AND;
    n_checks++;
    if (mem_state !== 2'b10) begin n_fail++; $display("FAIL mid-ldi INDIRECT: got %b expected 10", mem_state); end
    reset = 1'b1;
    @(negedge clock);
    n_checks++;
    if (mem_state !== 2'b11 || en_vec !== 5'b00000 || br_taken !== 1'b0)
      begin n_fail++; $display("FAIL mid-ldi reset: got ms=%b en=%b br=%b expected ms=11 en=00000 br=0",
                               mem_state, en_vec, br_taken); end
    reset = 1'b0;
    @(negedge clock);
    n_checks++;
    if (en_vec !== 5'b11000 || mem_state !== 2'b11)
      begin n_fail++; $display("FAIL mid-ldi restart: got ms=%b en=%b expected ms=11 en=11000", mem_state, en_vec); end
    repeat (3) @(negedge clock);
    n_checks++;
    if (en_vec !== 5'b11111) begin n_fail++; $display("FAIL mid-ldi refill: got %b expected 11111", en_vec); end
  endtask

  initial begin
    reset = 1'b1;
    IMem_dout = 16'h0000;
    IR = NOP_AND;
    IR_Exec = NOP_AND;
    NZP = 3'b000;
    psr = 3'b000;

    test_reset();
    test_mem_op(16'hA005, 3, {2'b11, 2'b00, 2'b10}, {5'b11111, 5'b00001, 5'b00000}, "ldi");
    test_mem_op(16'h7042, 2, {2'b11, 2'b11, 2'b01}, {5'b11111, 5'b11111, 5'b00000}, "str");
    test_mem_op(16'h6042, 2, {2'b11, 2'b11, 2'b00}, {5'b11111, 5'b11111, 5'b00001}, "ldr");
    test_mem_op(16'hB005, 3, {2'b11, 2'b01, 2'b10}, {5'b11111, 5'b00000, 5'b00000}, "sti");
    test_back_to_back();
    test_branch(16'h0403, 3'b010, 1'b1, "brz_taken");
    test_branch(16'h0403, 3'b001, 1'b0, "brz_not_taken");
    test_branch(16'hC1C0, 3'b000, 1'b1, "jmp");
    test_branch(16'h0003, 3'b111, 1'b0, "br_nzp000");
    test_forwarding();
    test_reset_mid_ldi();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
